perf_event_monitor: RTL and testbench
=====================================

Name: perf_event_monitor

Overview:
Synthesizable multi-channel performance monitor for the pipelined CPU.
- Counts per-cycle hazard events (stall, flush, etc.) and run cycles in hardware.
- Sits beside the CPU top level. Its event inputs come from the hazard-detection and flush units.
- A register-read port exposes the counts to the bench or a debug path.
- Adds a configurable cycle-limit auto-stop, saturating counters with sticky overflow, and an optional snapshot bank.

Parameters:
- NUM_CH, 4, number of independent event channels (1..16).
- CNT_W, 32, width of each event counter and of the cycle counter (8..32).
- CYCLE_LIMIT, 70, number of RUN cycles before auto-stop; 0 = never stop.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  level; 1 = run/keep running, 0 = pause.
- clear_i  in  1  synchronous clear of all counts and flags, returns to IDLE.
- event_i  in  NUM_CH  per-channel event, level-sampled, one count per cycle high.
- rd_sel_i  in  5  read select: 0..NUM_CH-1 = channel, NUM_CH = cycle counter.
- rd_snap_i  in  1  1 = read the snapshot bank (only with the optional feature).
- snap_i  in  1  capture all live counters into the snapshot bank (only with the optional feature).
- rd_data_o  out  CNT_W  registered read data.
- cycle_o  out  CNT_W  live cycle counter.
- running_o  out  1  state == RUN.
- done_o  out  1  state == DONE.
- overflow_o  out  NUM_CH  sticky per-channel saturation flag.

Behaviour:
- Reset (rst_i=1 at edge): state IDLE; all counters, cycle_o, rd_data_o, overflow_o, snapshot bank = 0; running_o=0; done_o=0.
- Priority at each edge: rst_i > clear_i > state logic.
  - clear_i zeroes counters, cycle_o, overflow_o and the snapshot bank, and forces IDLE.
  - An event arriving in the same cycle as clear_i is discarded.
- FSM states are IDLE, RUN and DONE.
  - IDLE: start_i=1 -> RUN. No counting in the transition cycle.
  - RUN: each cycle, cycle_o += 1 and channel k += 1 where event_i[k]=1. start_i=0 -> IDLE; counts are held (pause), and the increment of that cycle is still applied.
  - RUN auto-stop: if CYCLE_LIMIT != 0 and cycle_o == CYCLE_LIMIT-1, this edge increments to CYCLE_LIMIT and goes to DONE.
  - DONE: all counts frozen. start_i is ignored. Only clear_i or rst_i leave DONE.
- Resume from IDLE continues from the held counts; cycle_o is not reset.
- Saturation:
  - A counter at all-ones stays all-ones.
  - An event while saturated sets overflow_o[k], which stays set until clear or reset.
  - cycle_o saturates the same way, without a flag.
- Read port:
  - rd_data_o is updated at every edge from rd_sel_i, so it shows the value one cycle after the select.
  - rd_sel_i > NUM_CH returns 0.
  - Reading a counter in the same cycle it increments returns the pre-increment value.
- Events are counted only in RUN. Events in IDLE or DONE are ignored, including in the IDLE->RUN cycle.

Optional Feature:
Macro PERF_MON_SNAPSHOT_EN.
- Defined:
  - A shadow bank of NUM_CH+1 registers (channels plus cycle).
  - snap_i=1 copies the live values at that edge. The copy is the pre-increment value if an event coincides.
  - rd_snap_i=1 selects the shadow bank for rd_data_o.
  - snap_i works in any state except during reset/clear (clear wins).
- Not defined: snap_i and rd_snap_i are unused; no shadow registers are inferred; reads always return live values.

Decomposition:
- Package perf_mon_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the read-select constant for the cycle counter offset;
  - the maximum channel constant (16).
- Sub-module perf_sat_counter: one CNT_W saturating counter with inc, clear and overflow-flag outputs.
  - The top level instantiates NUM_CH of these plus one for cycles.
  - The top level owns the FSM and the read mux.

Test Plan:
1. Defaults (NUM_CH=4, CYCLE_LIMIT=70). Reset, then start_i=1 with event_i[0]=1 every 3rd RUN cycle -> done_o rises after the 70th RUN cycle; cycle_o=70; channel 0 reads 24 (RUN cycles 0,3,...,69); running_o=0.
2. Pause/resume. Run 10 cycles, start_i=0 for 5 cycles with event_i=4'hF, then run 10 more -> cycle_o=20; paused events not counted.
3. Saturation (CNT_W=8). Hold event_i[1]=1 for 300 RUN cycles, CYCLE_LIMIT=0 -> channel 1 reads 255; overflow_o[1]=1; other flags 0; cycle_o=255.
4. Clear collision. clear_i=1 in the same cycle as event_i=4'hF in RUN -> next cycle all counts 0, overflow_o=0, state IDLE.
5. Read latency. Set rd_sel_i=4 (cycle counter) at cycle N -> rd_data_o equals cycle_o sampled at that edge, one cycle later. rd_sel_i=9 -> 0.
6. With PERF_MON_SNAPSHOT_EN: snap_i at cycle_o=30, run to DONE, rd_snap_i=1 with rd_sel_i=4 -> reads 30 while live reads 70.

Source files
------------

// File: rtl/perf_mon_pkg.sv
// Shared types and constants for the performance event monitor.
// Holds the FSM encoding and the read-select layout used by the top level.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } monState_e;

  localparam int MAX_CH = 16;

  // The cycle counter sits directly after the last channel in the select space
  localparam int CYCLE_SEL_OFS = 0;

  localparam int SEL_W = $clog2(MAX_CH + 1);

  function automatic int cycleSel(input int numCh);
    return numCh + CYCLE_SEL_OFS;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// One saturating event counter with synchronous clear and an optional sticky
// overflow flag that records an increment request while already at all-ones.
module perf_sat_counter
  import perf_mon_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter bit FLAG_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // Clear dominates an increment in the same cycle; at all-ones the count holds
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf <= FLAG_EN;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// Multi-channel hazard/event performance monitor with cycle-limit auto-stop.
// Optional snapshot bank enabled by defining PERF_MON_SNAPSHOT_EN.
module perf_event_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 70
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  input  logic              rd_snap_i,
  input  logic              snap_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic              running_o,
  output logic              done_o,
  output logic [NUM_CH-1:0] overflow_o
);

  localparam int              CYC_SEL    = cycleSel(NUM_CH);
  localparam bit              LIMIT_EN   = (CYCLE_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(CYCLE_LIMIT - 1);

  monState_e        state;
  logic [CNT_W-1:0] chCount [NUM_CH];
  logic [CNT_W-1:0] cycleCount;
  logic             isRun;
  logic             limitHit;
  logic             unusedCycleOvf;
  logic [CNT_W-1:0] liveData;
  logic [CNT_W-1:0] readData;

  assign isRun    = (state == RUN);
  assign limitHit = LIMIT_EN && (cycleCount == LIMIT_LAST);
  assign cycle_o  = cycleCount;

  for (genvar k = 0; k < NUM_CH; k++) begin : gChannel
    perf_sat_counter #(
      .CNT_W   (CNT_W),
      .FLAG_EN (1'b1)
    ) uChCounter (
      .clock (clk_i),
      .reset (rst_i),
      .clear (clear_i),
      .inc   (isRun && event_i[k]),
      .count (chCount[k]),
      .ovf   (overflow_o[k])
    );
  end

  perf_sat_counter #(
    .CNT_W   (CNT_W),
    .FLAG_EN (1'b0)
  ) uCycleCounter (
    .clock (clk_i),
    .reset (rst_i),
    .clear (clear_i),
    .inc   (isRun),
    .count (cycleCount),
    .ovf   (unusedCycleOvf)
  );

  // Auto-stop wins over a pause request landing on the final counted cycle
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state     <= IDLE;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= RUN;
            running_o <= 1'b1;
          end
        end
        RUN: begin
          if (limitHit) begin
            state     <= DONE;
            running_o <= 1'b0;
            done_o    <= 1'b1;
          end else if (!start_i) begin
            state     <= IDLE;
            running_o <= 1'b0;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state     <= IDLE;
          running_o <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    liveData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_sel_i == SEL_W'(k)) liveData = chCount[k];
    end
    if (rd_sel_i == SEL_W'(CYC_SEL)) liveData = cycleCount;
  end

`ifdef PERF_MON_SNAPSHOT_EN
  logic [CNT_W-1:0] snapBank [NUM_CH+1];
  logic [CNT_W-1:0] snapData;

  // Captures the values present before this edge's increments
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int k = 0; k <= NUM_CH; k++) snapBank[k] <= '0;
    end else if (snap_i) begin
      for (int k = 0; k < NUM_CH; k++) snapBank[k] <= chCount[k];
      snapBank[NUM_CH] <= cycleCount;
    end
  end

  always_comb begin
    snapData = '0;
    for (int k = 0; k <= NUM_CH; k++) begin
      if (rd_sel_i == SEL_W'(k)) snapData = snapBank[k];
    end
  end

  assign readData = rd_snap_i ? snapData : liveData;
`else
  logic unusedSnapInputs;

  assign unusedSnapInputs = snap_i ^ rd_snap_i;
  assign readData         = liveData;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= readData;
    end
  end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed self-checking bench for perf_event_monitor with a read scoreboard.
// A second instance (CNT_W=8, no cycle limit) covers saturation.
module tb_perf_event_monitor;

  localparam int NUM_CH = 4;
  localparam int LIMIT  = 70;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, clr, snap, rdSnap;
  logic [3:0]  ev;
  logic [4:0]  sel;
  logic [31:0] rdData, cycleOut;
  logic        running, done;
  logic [3:0]  ovf;

  logic        satStart;
  logic [3:0]  satEv;
  logic [4:0]  satSel;
  logic [7:0]  satRd, satCycle;
  logic        satRunning, satDone;
  logic [3:0]  satOvf;

  int compareCount  = 0;
  int mismatchCount = 0;

  int          mState;
  logic [31:0] mCycle;
  logic [31:0] mCh [NUM_CH];
  logic [3:0]  mOvf;
  logic [31:0] mSnap [NUM_CH+1];
  logic [31:0] sbQ [$];

  perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(32), .CYCLE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clr), .event_i(ev),
    .rd_sel_i(sel), .rd_snap_i(rdSnap), .snap_i(snap), .rd_data_o(rdData),
    .cycle_o(cycleOut), .running_o(running), .done_o(done), .overflow_o(ovf)
  );

  perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(8), .CYCLE_LIMIT(0)) dutSat (
    .clk_i(clk), .rst_i(rst), .start_i(satStart), .clear_i(clr), .event_i(satEv),
    .rd_sel_i(satSel), .rd_snap_i(1'b0), .snap_i(1'b0), .rd_data_o(satRd),
    .cycle_o(satCycle), .running_o(satRunning), .done_o(satDone), .overflow_o(satOvf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expectedRead(input logic [4:0] s, input logic rs);
    logic [31:0] v;
    v = 32'd0;
    if (int'(s) < NUM_CH) v = mCh[int'(s)];
    else if (int'(s) == NUM_CH) v = mCycle;
`ifdef PERF_MON_SNAPSHOT_EN
    if (rs) v = (int'(s) <= NUM_CH) ? mSnap[int'(s)] : 32'd0;
`else
    if (rs) v = v;
`endif
    return v;
  endfunction

  task automatic modelReset();
    mState = 0;
    mCycle = 32'd0;
    mOvf   = 4'd0;
    for (int k = 0; k < NUM_CH; k++) mCh[k] = 32'd0;
    for (int k = 0; k <= NUM_CH; k++) mSnap[k] = 32'd0;
  endtask

  task automatic modelEdge(input logic st, input logic [3:0] e, input logic c, input logic sn);
    logic atLast;
    if (c) begin
      modelReset();
    end else begin
      if (sn) begin
        for (int k = 0; k < NUM_CH; k++) mSnap[k] = mCh[k];
        mSnap[NUM_CH] = mCycle;
      end
      case (mState)
        0: if (st) mState = 1;
        1: begin
          atLast = (LIMIT != 0) && (mCycle == 32'(LIMIT - 1));
          for (int k = 0; k < NUM_CH; k++) begin
            if (e[k]) begin
              if (mCh[k] == CNT_MAX) mOvf[k] = 1'b1;
              else mCh[k] = mCh[k] + 32'd1;
            end
          end
          if (mCycle != CNT_MAX) mCycle = mCycle + 32'd1;
          if (atLast) mState = 2;
          else if (!st) mState = 0;
        end
        default: mState = mState;
      endcase
    end
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge
  task automatic applyStimulus(input logic st, input logic [3:0] e, input logic c,
                               input logic [4:0] s, input logic sn, input logic rs);
    start  = st;
    ev     = e;
    clr    = c;
    sel    = s;
    snap   = sn;
    rdSnap = rs;
    sbQ.push_back(expectedRead(s, rs));
    @(posedge clk);
    modelEdge(st, e, c, sn);
    @(negedge clk);
    checkOutput("rd_data", rdData, sbQ.pop_front());
    checkOutput("cycle", cycleOut, mCycle);
    checkOutput("running", 32'(running), 32'(mState == 1));
    checkOutput("done", 32'(done), 32'(mState == 2));
    checkOutput("overflow", 32'(ovf), 32'(mOvf));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0; snap = 1'b0; rdSnap = 1'b0;
    ev = 4'd0; sel = 5'd0;
    satStart = 1'b0; satEv = 4'd0; satSel = 5'd0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_rd", rdData, 32'd0);
    checkOutput("reset_cycle", cycleOut, 32'd0);
    checkOutput("reset_running", 32'(running), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);

    $display("[TB] auto-stop at cycle limit");
    applyStimulus(1'b1, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int r = 0; r < LIMIT; r++)
      applyStimulus(1'b1, (r % 3 == 0) ? 4'h1 : 4'h0, 1'b0, 5'(r % 5), 1'b0, 1'b0);
    checkOutput("t1_cycle", cycleOut, 32'd70);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_running", 32'(running), 32'd0);
    applyStimulus(1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("t1_ch0", rdData, 32'd24);
    applyStimulus(1'b1, 4'hF, 1'b0, 5'd4, 1'b0, 1'b0);
    checkOutput("t1_cyc_rd", rdData, 32'd70);
    checkOutput("t1_frozen", cycleOut, 32'd70);

    $display("[TB] pause and resume");
    applyStimulus(1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkOutput("t2_cleared_done", 32'(done), 32'd0);
    applyStimulus(1'b1, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int r = 0; r < 9; r++) applyStimulus(1'b1, 4'h0, 1'b0, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 5'd4, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) applyStimulus(1'b0, 4'hF, 1'b0, 5'(r % 4), 1'b0, 1'b0);
    checkOutput("t2_paused_cycle", cycleOut, 32'd10);
    applyStimulus(1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int r = 0; r < 9; r++) applyStimulus(1'b1, 4'h0, 1'b0, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 5'd4, 1'b0, 1'b0);
    checkOutput("t2_cycle", cycleOut, 32'd20);
    for (int k = 0; k < NUM_CH; k++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 5'(k), 1'b0, 1'b0);
      checkOutput("t2_ch_zero", rdData, 32'd0);
    end

    $display("[TB] read latency and out-of-range select");
    applyStimulus(1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int r = 0; r < 7; r++) applyStimulus(1'b1, 4'h2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 5'd4, 1'b0, 1'b0);
    checkOutput("t5_cycle_rd", rdData, 32'd7);
    applyStimulus(1'b1, 4'h2, 1'b0, 5'd1, 1'b0, 1'b0);
    checkOutput("t5_preinc_rd", rdData, 32'd8);
    applyStimulus(1'b1, 4'h2, 1'b0, 5'd9, 1'b0, 1'b0);
    checkOutput("t5_sel9", rdData, 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b0, 5'd5, 1'b0, 1'b0);
    checkOutput("t5_sel5", rdData, 32'd0);

    $display("[TB] saturation on 8-bit instance");
    satStart = 1'b1;
    satEv    = 4'h0;
    @(negedge clk);
    for (int r = 0; r < 300; r++) begin
      satEv = 4'b0010;
      @(negedge clk);
    end
    satEv  = 4'h0;
    satSel = 5'd1;
    @(negedge clk);
    checkOutput("t3_ch1", 32'(satRd), 32'd255);
    checkOutput("t3_ovf", 32'(satOvf), 32'b0010);
    checkOutput("t3_cycle", 32'(satCycle), 32'd255);
    checkOutput("t3_running", 32'(satRunning), 32'd1);
    checkOutput("t3_done", 32'(satDone), 32'd0);
    satSel = 5'd4;
    @(negedge clk);
    checkOutput("t3_cycle_rd", 32'(satRd), 32'd255);
    satStart = 1'b0;

    $display("[TB] clear colliding with events");
    applyStimulus(1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkOutput("t4_sat_ovf_cleared", 32'(satOvf), 32'd0);
    applyStimulus(1'b1, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) applyStimulus(1'b1, 4'hF, 1'b0, 5'(r % 4), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b1, 5'd2, 1'b0, 1'b0);
    checkOutput("t4_precleared_rd", rdData, 32'd5);
    checkOutput("t4_cycle", cycleOut, 32'd0);
    checkOutput("t4_ovf", 32'(ovf), 32'd0);
    checkOutput("t4_running", 32'(running), 32'd0);
    for (int k = 0; k <= NUM_CH; k++) begin
      applyStimulus(1'b0, 4'hF, 1'b0, 5'(k), 1'b0, 1'b0);
      checkOutput("t4_zero_rd", rdData, 32'd0);
    end

    $display("[TB] snapshot capture");
    applyStimulus(1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int r = 0; r < LIMIT; r++)
      applyStimulus(1'b1, 4'h8, 1'b0, 5'd3, (r == 30), 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 5'd4, 1'b0, 1'b1);
`ifdef PERF_MON_SNAPSHOT_EN
    checkOutput("t6_snap_cycle", rdData, 32'd30);
`else
    checkOutput("t6_snap_cycle", rdData, 32'd70);
`endif
    applyStimulus(1'b0, 4'h0, 1'b0, 5'd4, 1'b0, 1'b0);
    checkOutput("t6_live_cycle", rdData, 32'd70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
